// File: rtl/write_back.sv
// Commit stage of the multicycle core: writes results into the integer/float
// register files and the PC, and serves the combinational register reads for decode.
module write_back #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic [2:0]  wselector,
  input  logic [31:0] data,
  input  logic [31:0] pc_in,
  input  logic [4:0]  rd,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  fa1,
  input  logic [4:0]  fa2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] fd1,
  output logic [31:0] fd2,
  output logic [31:0] pc,
  output logic        done,
  output logic [31:0] retired,
  output logic        sel_err
);

  logic [31:0] gpr [32];
  logic [31:0] fpr [32];

  logic        gpr_we;
  logic        fpr_we;
  logic        illegal;
  logic [31:0] pc_next;

  // Selector decode; bit 2 alone chooses the PC source, even for illegal codes
  always_comb begin
    gpr_we  = 1'b0;
    fpr_we  = 1'b0;
    illegal = 1'b0;
    case (wselector)
      3'b000: gpr_we = 1'b0;
      3'b010: gpr_we = (rd != 5'd0);
      3'b011: fpr_we = 1'b1;
      3'b100: gpr_we = 1'b0;
      3'b110: gpr_we = (rd != 5'd0);
      default: illegal = 1'b1;
    endcase
    if (wselector[2]) begin
      pc_next = {pc_in[31:2], 2'b00};
    end else begin
      pc_next = pc + 32'd4;
    end
  end

  // Commit state: register files, PC, retire counter, done pulse and error flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc      <= RESET_PC;
      done    <= 1'b0;
      retired <= 32'd0;
      sel_err <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        gpr[i] <= 32'd0;
        fpr[i] <= 32'd0;
      end
    end else begin
      done <= enable;
      if (enable) begin
        pc      <= pc_next;
        retired <= retired + 32'd1;
        if (illegal) sel_err <= 1'b1;
        if (gpr_we)  gpr[rd] <= data;
        if (fpr_we)  fpr[rd] <= data;
      end
    end
  end

  // No write bypass: a read in the commit cycle returns the old value
  assign rd1 = (ra1 == 5'd0) ? 32'd0 : gpr[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : gpr[ra2];
  assign fd1 = fpr[fa1];
  assign fd2 = fpr[fa2];

endmodule

// File: tb/tb_write_back.sv
// Directed self-checking bench for write_back with hand-computed expectations.
module tb_write_back;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic [2:0]  wselector = 3'b000;
  logic [31:0] data = 32'd0;
  logic [31:0] pc_in = 32'd0;
  logic [4:0]  rd = 5'd0;
  logic [4:0]  ra1 = 5'd0, ra2 = 5'd0, fa1 = 5'd0, fa2 = 5'd0;
  logic [31:0] rd1, rd2, fd1, fd2, pc, retired;
  logic        done, sel_err;

  int compared = 0;
  int mismatched = 0;

  write_back #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .wselector(wselector),
    .data(data), .pc_in(pc_in), .rd(rd),
    .ra1(ra1), .ra2(ra2), .fa1(fa1), .fa2(fa2),
    .rd1(rd1), .rd2(rd2), .fd1(fd1), .fd2(fd2),
    .pc(pc), .done(done), .retired(retired), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one enable pulse; returns 1 time unit after the committing edge.
  task automatic commit(input logic [2:0] s, input logic [4:0] d,
                        input logic [31:0] dat, input logic [31:0] p);
    @(negedge clk);
    wselector = s; rd = d; data = dat; pc_in = p; enable = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
  endtask

  initial begin
    #3;
    chk("reset_pc_async", pc, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ra1 = i[4:0]; ra2 = i[4:0]; fa1 = i[4:0]; fa2 = i[4:0];
      #1;
      chk("reset_gpr_rd1", rd1, 32'd0);
      chk("reset_gpr_rd2", rd2, 32'd0);
      chk("reset_fpr_fd1", fd1, 32'd0);
      chk("reset_fpr_fd2", fd2, 32'd0);
    end
    chk("reset_pc", pc, 32'h0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_retired", retired, 32'd0);
    chk("reset_sel_err", {31'd0, sel_err}, 32'd0);

    commit(3'b100, 5'd0, 32'd0, 32'h100);
    chk("jump_100_pc", pc, 32'h100);
    chk("jump_100_retired", retired, 32'd1);

    // GPR write, with the old value visible in the commit cycle
    ra1 = 5'd5;
    @(negedge clk);
    wselector = 3'b010; rd = 5'd5; data = 32'hDEADBEEF; enable = 1'b1;
    #1;
    chk("gpr5_old_value", rd1, 32'd0);
    @(posedge clk);
    #1;
    enable = 1'b0;
    chk("gpr5_write", rd1, 32'hDEADBEEF);
    chk("gpr5_pc", pc, 32'h104);
    chk("gpr5_done", {31'd0, done}, 32'd1);
    chk("gpr5_retired", retired, 32'd2);
    @(posedge clk);
    #1;
    chk("gpr5_done_low", {31'd0, done}, 32'd0);

    ra1 = 5'd0;
    commit(3'b010, 5'd0, 32'h12345678, 32'd0);
    chk("gpr0_hardwired", rd1, 32'd0);
    chk("gpr0_pc", pc, 32'h108);
    chk("gpr0_retired", retired, 32'd3);

    fa1 = 5'd0; ra1 = 5'd5;
    commit(3'b011, 5'd0, 32'h3F800000, 32'd0);
    chk("fpr0_write", fd1, 32'h3F800000);
    chk("fpr_gpr_untouched", rd1, 32'hDEADBEEF);
    chk("fpr0_pc", pc, 32'h10C);

    ra2 = 5'd31;
    commit(3'b110, 5'd31, 32'h208, 32'h00000403);
    chk("jal_link", rd2, 32'h208);
    chk("jal_pc_aligned", pc, 32'h400);
    chk("jal_retired", retired, 32'd5);

    commit(3'b100, 5'd5, 32'h0000AAAA, 32'h40);
    chk("jump_40_pc", pc, 32'h40);
    chk("jump_40_no_gpr", rd1, 32'hDEADBEEF);
    chk("jump_40_gpr31", rd2, 32'h208);
    chk("jump_40_fpr", fd1, 32'h3F800000);

    commit(3'b101, 5'd5, 32'h00001111, 32'h80);
    chk("illegal101_pc", pc, 32'h80);
    chk("illegal101_sel_err", {31'd0, sel_err}, 32'd1);
    chk("illegal101_no_write", rd1, 32'hDEADBEEF);
    chk("illegal101_retired", retired, 32'd7);

    ra2 = 5'd6; fa2 = 5'd6;
    commit(3'b001, 5'd6, 32'h00002222, 32'h200);
    chk("illegal001_pc_inc", pc, 32'h84);
    chk("illegal001_no_gpr", rd2, 32'd0);
    chk("illegal001_no_fpr", fd2, 32'd0);

    commit(3'b000, 5'd6, 32'h00003333, 32'h200);
    chk("nop_pc", pc, 32'h88);
    chk("sel_err_sticky", {31'd0, sel_err}, 32'd1);
    chk("nop_no_write", rd2, 32'd0);
    chk("nop_retired", retired, 32'd9);

    // Inputs ignored while enable is low
    ra2 = 5'd7;
    @(negedge clk);
    wselector = 3'b110; rd = 5'd7; data = 32'h77777777; pc_in = 32'h300;
    @(posedge clk);
    #1;
    chk("idle_no_write", rd2, 32'd0);
    chk("idle_pc_hold", pc, 32'h88);
    chk("idle_retired_hold", retired, 32'd9);

    commit(3'b100, 5'd0, 32'd0, 32'hFFFFFFFF);
    chk("pc_max", pc, 32'hFFFFFFFC);
    commit(3'b000, 5'd0, 32'd0, 32'd0);
    chk("pc_wrap", pc, 32'h0);
    chk("wrap_retired", retired, 32'd11);

    // Back-to-back commits; second sees the first's PC and GPR write
    ra1 = 5'd8;
    @(negedge clk);
    wselector = 3'b010; rd = 5'd8; data = 32'h00000011; enable = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b_first_done", {31'd0, done}, 32'd1);
    chk("b2b_first_pc", pc, 32'h4);
    @(negedge clk);
    wselector = 3'b000; rd = 5'd8; data = 32'h0;
    @(posedge clk);
    #1;
    enable = 1'b0;
    chk("b2b_second_done", {31'd0, done}, 32'd1);
    chk("b2b_second_pc", pc, 32'h8);
    chk("b2b_retired", retired, 32'd13);
    chk("b2b_gpr8", rd1, 32'h11);
    @(posedge clk);
    #1;
    chk("b2b_done_low", {31'd0, done}, 32'd0);

    // Asynchronous reset between edges
    ra1 = 5'd5; ra2 = 5'd31; fa1 = 5'd0;
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst_pc", pc, 32'h0);
    chk("async_rst_retired", retired, 32'd0);
    chk("async_rst_sel_err", {31'd0, sel_err}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    chk("async_rst_gpr5", rd1, 32'd0);
    chk("async_rst_gpr31", rd2, 32'd0);
    chk("async_rst_fpr0", fd1, 32'd0);

    // Commit under reset is lost; first enabled edge after release commits
    wselector = 3'b010; rd = 5'd5; data = 32'hCAFEF00D; enable = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_commit_lost", retired, 32'd0);
    chk("rst_commit_lost_gpr", rd1, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    enable = 1'b0;
    chk("post_rst_retired", retired, 32'd1);
    chk("post_rst_gpr5", rd1, 32'hCAFEF00D);
    chk("post_rst_pc", pc, 32'h4);
    chk("post_rst_done", {31'd0, done}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/write_back.md
# write_back

Final stage of the multicycle core, directly downstream of the execute stage. Consumes the execute stage's one-cycle completion pulse together with its write selector, result data, next-PC and destination register. Commits the result into the 32-entry integer register file, the 32-entry float register file and/or the program counter. Raises a one-cycle `done` that restarts fetch, and serves the combinational register reads used by decode.

## Interface
- `RESET_PC`, 32'h0, program counter value after reset
- `clk`  input  1  single clock; all state updates on rising edge
- `rstn`  input  1  reset, asynchronous, active-low
- `enable`  input  1  one-cycle pulse from execute: commit this cycle's inputs
- `wselector`  input  3  commit selector from execute (encoding under Operation)
- `data`  input  32  result to write to a register file
- `pc_in`  input  32  branch/jump target from execute
- `rd`  input  5  destination register index
- `ra1`, `ra2`  input  5 each  integer register read addresses
- `fa1`, `fa2`  input  5 each  float register read addresses
- `rd1`, `rd2`  output  32 each  integer read data
- `fd1`, `fd2`  output  32 each  float read data
- `pc`  output  32  current program counter, to fetch
- `done`  output  1  one-cycle pulse: commit finished, fetch may start
- `retired`  output  32  count of committed instructions
- `sel_err`  output  1  sticky flag: illegal selector seen

## Operation
- Selector decode on `enable`. Bit 2 means "PC from `pc_in`"; otherwise PC <= PC + 4.
  - 3'b000: no register write; PC += 4.
  - 3'b010: GPR[rd] <= data; PC += 4.
  - 3'b011: FPR[rd] <= data; PC += 4.
  - 3'b100: PC <= pc_in; no register write.
  - 3'b110: GPR[rd] <= data; PC <= pc_in (jump-and-link).
  - 3'b001, 3'b101, 3'b111: illegal. No register write. PC updates per bit 2. `sel_err` <= 1.
- GPR[0] is hardwired zero. Writes to index 0 are dropped and `rd1`/`rd2` read 0 for address 0. FPR[0] is an ordinary writable register.
- `pc_in` bits [1:0] are forced to 00 on commit. PC + 4 wraps modulo 2^32.
- Reads are combinational from the arrays, with no write bypass. A read in the commit cycle returns the old value; the new value is visible the cycle after.
- `retired` increments by 1 on every `enable`, including illegal selectors, and wraps from 32'hFFFFFFFF to 0.
- `sel_err` is sticky and clears only on reset.
- `enable` while `done` is high is legal and is committed normally; the block has no backpressure.
- Inputs other than `enable` are ignored when `enable` = 0.

## Timing
- Reset, asynchronous, applies immediately regardless of `clk`:
  - `pc` = RESET_PC, `done` = 0, `retired` = 0, `sel_err` = 0.
  - All GPR and FPR entries = 0.
- Reset asserted in the same cycle as `enable` loses the commit. After release, the first edge with `enable` commits normally.
- Commit latency:
  - `enable` sampled high at edge N updates arrays, `pc`, `retired` and `sel_err` at edge N.
  - `done` is high for exactly the cycle following edge N and low otherwise.
- Back-to-back `enable` on consecutive edges gives consecutive commits and `done` high for two cycles. The second commit sees the first's register and PC results.
- Read outputs follow address changes within the same cycle.

## Test plan
- Reset, then read all 32 GPR and FPR addresses -> all 0; `pc` = RESET_PC; `done`, `retired`, `sel_err` = 0.
- `enable`, sel 010, rd = 5, data = 32'hDEADBEEF, pc = 32'h100 -> next cycle `rd1`(ra1 = 5) = DEADBEEF, `pc` = 32'h104, `done` = 1 for one cycle, `retired` = 1. Repeat with rd = 0 -> `rd1`(ra1 = 0) stays 0.
- sel 011, rd = 0, data = 32'h3F800000 -> `fd1`(fa1 = 0) = 3F800000; GPR unchanged.
- sel 110, rd = 31, data = 32'h208, pc_in = 32'h00000403 -> GPR[31] = 32'h208, `pc` = 32'h400. Then sel 100, pc_in = 32'h40 -> `pc` = 32'h40, no register change.
- sel 101, pc_in = 32'h80 -> `pc` = 32'h80, no writes, `sel_err` = 1 and stays 1 across later legal commits until reset.
- Mid-run: drive `pc` to 32'hFFFFFFFC, then sel 000 -> `pc` = 0. Assert `rstn` = 0 between edges -> all outputs reset with no clock edge. Two consecutive `enable` pulses -> `retired` += 2 and `done` high for two cycles.
